bfu_pipe: RTL and testbench
===========================

BFU_PIPE -- requirements
Module: bfu_pipe

Interface
REQ-001 Parameter Q, default 8380417, the Dilithium modulus; the only supported value.
REQ-002 Parameter DATA_W, default 23, coefficient width in bits.
REQ-003 Parameter LATENCY, default 11, input-to-output delay in cycles; the only supported value.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port valid_in, input, 1, marks a, b, omiga and sel_keep as a valid operation this cycle.
REQ-007 Port sel_keep, input, 1, selects the butterfly: 0 = DIT (Cooley-Tukey), 1 = DIF (Gentleman-Sande).
REQ-008 Port a, input, DATA_W, upper butterfly operand, range [0, Q-1].
REQ-009 Port b, input, DATA_W, lower butterfly operand, range [0, Q-1].
REQ-010 Port omiga, input, DATA_W, twiddle factor, range [0, Q-1]; the INTT negation is already applied upstream.
REQ-011 Port a1, output, DATA_W, upper butterfly result, registered.
REQ-012 Port b1, output, DATA_W, lower butterfly result, registered.
REQ-013 Port valid_out, output, 1, valid_in delayed by exactly LATENCY cycles.

Function
REQ-014 The block is fully pipelined with initiation interval 1: it accepts a new operation every cycle and never stalls (no ready or back-pressure).
REQ-015 a, b, omiga and sel_keep are sampled in the same cycle; a1, b1 and valid_out for that operation appear exactly 11 cycles later.
REQ-016 sel_keep travels down the pipeline with its own operation, so consecutive operations may use different modes with no bubble.
REQ-017 DIT: t = (omiga*b) mod Q; a1 = (a+t) mod Q; b1 = (a-t) mod Q.
REQ-018 DIF: a1 = (a+b) mod Q; b1 = (((a-b) mod Q) * omiga) mod Q.
REQ-019 No scaling by n^-1 is applied inside this block.
REQ-020 Every output value lies in [0, Q-1]; a value equal to Q never appears on a1 or b1.
REQ-021 The product is the full 46-bit omiga*x with no truncation before reduction.
REQ-022 Reduction uses 2^23 ≡ 2^13-1 (mod Q) in shift-add stages (no divider), followed by final conditional subtractions.
REQ-023 The multiply is split over 3 stages and the reduction over 5 stages; the add/sub and balancing registers bring the total to 11 stages in both modes.
REQ-024 Modular add: if the sum is >= Q, subtract Q.
REQ-025 Modular subtract: if the difference is negative, add Q.
REQ-026 Both modes use the same stage count, so the DIT and DIF paths are latency-matched.
REQ-027 The datapath advances regardless of valid_in.
REQ-028 While valid_out is 0, a1 and b1 hold whatever data entered 11 cycles earlier; downstream ignores them.
REQ-029 Behaviour for operands >= Q is unspecified.

Reset
REQ-030 While rst=1 at a clock edge, every pipeline register, including the valid shift chain, a1, b1 and valid_out, is cleared to 0.
REQ-031 Operations in flight when rst is asserted are discarded; no valid_out pulse for them ever appears.
REQ-032 In the first cycle after rst deasserts, the block accepts a new operation; its result appears 11 cycles later.
REQ-033 rst held for several cycles keeps all outputs at 0.

Verification
REQ-034 DIT, a=1, b=1, omiga=1, valid_in one cycle -> 11 cycles later valid_out=1, a1=2, b1=0.
REQ-035 DIT, a=0, b=8380416, omiga=8380416 -> a1=1, b1=8380416 (checks the (Q-1)^2 reduction).
REQ-036 DIF, a=5, b=7, omiga=2 -> a1=12, b1=8380413; DIF, a=8380416, b=8380416, omiga=12345 -> a1=8380415, b1=0.
REQ-037 256 back-to-back random operations with sel_keep toggling every cycle -> every a1/b1 matches the golden model, with valid_out exactly 11 cycles after its valid_in and no gaps.
REQ-038 rst asserted for 1 cycle with 5 operations in flight -> valid_out, a1 and b1 are 0 the next cycle, and no valid_out pulse appears in the following 20 cycles without new input.
REQ-039 Directed boundaries: a=0/b=0, a=Q-1/b=Q-1, omiga=0, omiga=1, a=b -> all results in [0, Q-1] and equal to the model.

Source files
------------

// File: rtl/bfu_pipe.sv
// bfu_pipe: fully pipelined modular butterfly unit for the Dilithium NTT/INTT
// over Z_q (q = 8380417). It accepts one operation per cycle and never stalls.
//
//   sel_keep = 0 (DIT / Cooley-Tukey):   t  = omiga*b mod q
//                                        a1 = a + t mod q,  b1 = a - t mod q
//   sel_keep = 1 (DIF / Gentleman-Sande): a1 = a + b mod q
//                                        b1 = (a - b mod q) * omiga mod q
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset, clears every register
//   valid_in   in   1       a, b, omiga, sel_keep carry a valid operation
//   sel_keep   in   1       butterfly mode, travels with its own operation
//   a, b       in   DATA_W  operands in [0, q-1]
//   omiga      in   DATA_W  twiddle in [0, q-1]
//   a1, b1     out  DATA_W  registered results in [0, q-1]
//   valid_out  out  1       valid_in delayed by LATENCY cycles
//
// Stage map (one register per stage, 11 total):
//   p0 input | p1 DIF add/sub | p2-p4 multiply | p5-p9 reduce | p10 DIT add/sub
// In DIT mode p1 is a pass-through; in DIF mode p10 is, so both modes share
// the same latency and the multiplier/reducer serve both butterflies.
module bfu_pipe #(
   parameter int Q       = 8380417,
   parameter int DATA_W  = 23,
   parameter int LATENCY = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              sel_keep,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] omiga,
   output logic [DATA_W-1:0] a1,
   output logic [DATA_W-1:0] b1,
   output logic              valid_out
);

   localparam int PW      = 2 * DATA_W;     // full product width
   localparam int LO_W    = 12;             // low half of a split operand
   localparam int HI_W    = DATA_W - LO_W;  // high half of a split operand
   localparam int PP_W    = 2 * LO_W;       // partial-product register width
   localparam int MID_W   = PP_W + 1;       // sum of the two cross products
   localparam int FOLD_SH = 13;             // 2^23 = 2^13 - 1 (mod q)

   localparam logic        [PW-1:0]     Q_W = PW'(Q);
   localparam logic        [DATA_W:0]   Q_A = (DATA_W + 1)'(Q);
   localparam logic signed [DATA_W+1:0] Q_S = (DATA_W + 2)'(Q);

   // Modular add of two residues: one conditional subtraction suffices.
   function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
      logic [DATA_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return (s >= Q_A) ? DATA_W'(s - Q_A) : DATA_W'(s);
   endfunction

   // Modular subtract of two residues: add q back when the difference is negative.
   function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
      logic signed [DATA_W+1:0] d;
      d = $signed({2'b00, x}) - $signed({2'b00, y});
      return (d < 0) ? DATA_W'(d + Q_S) : DATA_W'(d);
   endfunction

   // One folding step: v = hi*2^23 + lo  ->  hi*2^13 - hi + lo.
   // hi*2^13 >= hi, so the result never goes negative.
   function automatic logic [PW-1:0] fold(input logic [PW-1:0] v);
      return (PW'(v[PW-1:DATA_W]) << FOLD_SH) - PW'(v[PW-1:DATA_W])
             + PW'(v[DATA_W-1:0]);
   endfunction

   // Conditional subtraction keeping the full width.
   function automatic logic [PW-1:0] cond_sub(input logic [PW-1:0] v);
      return (v >= Q_W) ? (v - Q_W) : v;
   endfunction

   // Conditional subtraction that also narrows to a residue.
   function automatic logic [DATA_W-1:0] final_sub(input logic [PW-1:0] v);
      return (v >= Q_W) ? DATA_W'(v - Q_W) : DATA_W'(v);
   endfunction

   logic [DATA_W-1:0]  a_p0, b_p0, w_p0;
   logic [DATA_W-1:0]  x_p1, w_p1;
   logic [PP_W-1:0]    ll_p2, lh_p2, hl_p2, hh_p2;
   logic [PP_W-1:0]    ll_p3, hh_p3;
   logic [MID_W-1:0]   mid_p3;
   logic [PW-1:0]      prod_p4;
   logic [PW-1:0]      r_p5, r_p6, r_p7, r_p8;
   logic [DATA_W-1:0]  t_p9;
   logic [DATA_W-1:0]  u_dly   [1:9];   // upper operand / DIF sum riding alongside
   logic               sel_dly [0:9];
   logic [LATENCY-1:0] vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_p0    <= '0;
         b_p0    <= '0;
         w_p0    <= '0;
         x_p1    <= '0;
         w_p1    <= '0;
         ll_p2   <= '0;
         lh_p2   <= '0;
         hl_p2   <= '0;
         hh_p2   <= '0;
         ll_p3   <= '0;
         hh_p3   <= '0;
         mid_p3  <= '0;
         prod_p4 <= '0;
         r_p5    <= '0;
         r_p6    <= '0;
         r_p7    <= '0;
         r_p8    <= '0;
         t_p9    <= '0;
         for (int i = 1; i <= 9; i++) u_dly[i] <= '0;
         for (int i = 0; i <= 9; i++) sel_dly[i] <= 1'b0;
         a1      <= '0;
         b1      <= '0;
         vld     <= '0;
      end else begin
         // p0: capture operation
         a_p0       <= a;
         b_p0       <= b;
         w_p0       <= omiga;
         sel_dly[0] <= sel_keep;

         // p1: DIF pre-butterfly (pass-through for DIT)
         if (sel_dly[0]) begin
            u_dly[1] <= mod_add(a_p0, b_p0);
            x_p1     <= mod_sub(a_p0, b_p0);
         end else begin
            u_dly[1] <= a_p0;
            x_p1     <= b_p0;
         end
         w_p1       <= w_p0;
         sel_dly[1] <= sel_dly[0];

         // p2: four 12x12-class partial products of omiga*x
         ll_p2 <= PP_W'(w_p1[LO_W-1:0])      * PP_W'(x_p1[LO_W-1:0]);
         lh_p2 <= PP_W'(w_p1[LO_W-1:0])      * PP_W'(x_p1[DATA_W-1:LO_W]);
         hl_p2 <= PP_W'(w_p1[DATA_W-1:LO_W]) * PP_W'(x_p1[LO_W-1:0]);
         hh_p2 <= PP_W'(w_p1[DATA_W-1:LO_W]) * PP_W'(x_p1[DATA_W-1:LO_W]);

         // p3: merge the cross terms
         ll_p3  <= ll_p2;
         hh_p3  <= hh_p2;
         mid_p3 <= MID_W'(lh_p2) + MID_W'(hl_p2);

         // p4: full 46-bit product
         prod_p4 <= (PW'(hh_p3) << (2 * LO_W)) + (PW'(mid_p3) << LO_W) + PW'(ll_p3);

         // p5-p7: three folds bring the product below 2^23 + 2^18
         r_p5 <= fold(prod_p4);
         r_p6 <= fold(r_p5);
         r_p7 <= fold(r_p6);

         // p8-p9: final conditional subtractions into [0, q-1]
         r_p8 <= cond_sub(r_p7);
         t_p9 <= final_sub(r_p8);

         for (int i = 2; i <= 9; i++) begin
            u_dly[i]   <= u_dly[i-1];
            sel_dly[i] <= sel_dly[i-1];
         end

         // p10: DIT post-butterfly (pass-through for DIF)
         if (sel_dly[9]) begin
            a1 <= u_dly[9];
            b1 <= t_p9;
         end else begin
            a1 <= mod_add(u_dly[9], t_p9);
            b1 <= mod_sub(u_dly[9], t_p9);
         end

         vld <= {vld[LATENCY-2:0], valid_in};
      end
   end

   assign valid_out = vld[LATENCY-1];

endmodule

// File: tb/tb_bfu_pipe.sv
// Testbench for bfu_pipe: directed vector table, back-to-back random stream
// against a behavioural model, and reset corner cases.
module tb_bfu_pipe;

   localparam int  DATA_W = 23;
   localparam int  LAT    = 11;
   localparam longint QL  = 8380417;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_in;
   logic              sel_keep;
   logic [DATA_W-1:0] a, b, omiga;
   logic [DATA_W-1:0] a1, b1;
   logic              valid_out;

   int errors = 0;
   int checks = 0;

   bfu_pipe #(.Q(8380417), .DATA_W(DATA_W), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .sel_keep(sel_keep),
      .a(a), .b(b), .omiga(omiga), .a1(a1), .b1(b1), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit sel;
      int va, vb, vw;
      int ea, eb;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void model(input bit sel, input longint x, input longint y,
                                 input longint w, output longint ea, output longint eb);
      longint t;
      if (!sel) begin
         t  = (w * y) % QL;
         ea = (x + t) % QL;
         eb = (x - t + QL) % QL;
      end else begin
         ea = (x + y) % QL;
         eb = (((x - y + QL) % QL) * w) % QL;
      end
   endfunction

   task automatic drive(input bit v, input bit s, input int x, input int y, input int w);
      valid_in = v;
      sel_keep = s;
      a        = DATA_W'(x);
      b        = DATA_W'(y);
      omiga    = DATA_W'(w);
   endtask

   // random stream storage
   bit     r_sel [256];
   longint r_ea  [256];
   longint r_eb  [256];

   initial begin
      longint ea, eb;
      int     x, y, w;

      vecs[0]  = '{0, 1, 1, 1, 2, 0};
      vecs[1]  = '{0, 0, 8380416, 8380416, 1, 8380416};
      vecs[2]  = '{1, 5, 7, 2, 12, 8380413};
      vecs[3]  = '{1, 8380416, 8380416, 12345, 8380415, 0};
      vecs[4]  = '{0, 0, 0, 5, 0, 0};
      vecs[5]  = '{1, 0, 0, 7, 0, 0};
      vecs[6]  = '{0, 8380416, 8380416, 8380416, 0, 8380415};
      vecs[7]  = '{1, 8380416, 8380416, 8380416, 8380415, 0};
      vecs[8]  = '{0, 100, 200, 0, 100, 100};
      vecs[9]  = '{0, 100, 200, 1, 300, 8380317};
      vecs[10] = '{1, 100, 50, 0, 150, 0};
      vecs[11] = '{1, 100, 200, 1, 300, 8380317};
      vecs[12] = '{0, 1000, 1000, 3, 4000, 8378417};
      vecs[13] = '{1, 1000, 1000, 3, 2000, 0};
      vecs[14] = '{0, 5, 2, 4194304, 8196, 8372231};
      vecs[15] = '{1, 8380416, 0, 2, 8380416, 8380415};

      // reset held for several cycles with busy inputs keeps outputs at 0
      rst = 1'b1;
      drive(1'b0, 1'b0, 0, 0, 0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c > 0) begin
            chk($sformatf("rst_hold%0d_valid", c), valid_out, 0);
            chk($sformatf("rst_hold%0d_a1", c), a1, 0);
            chk($sformatf("rst_hold%0d_b1", c), b1, 0);
         end
         drive(1'b1, c[0], 8380416 - c, 1234 + c, 77 * c + 3);
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      rst = 1'b0;
      repeat (LAT + 2) begin
         @(negedge clk);
         chk("after_rst_no_valid", valid_out, 0);
      end

      // directed table: one op at a time, exact latency checked
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(1'b1, vecs[i].sel, vecs[i].va, vecs[i].vb, vecs[i].vw);
         @(negedge clk);
         drive(1'b0, 1'b0, 0, 0, 0);
         repeat (LAT - 2) @(negedge clk);
         chk($sformatf("vec%0d_early_valid", i), valid_out, 0);
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), valid_out, 1);
         chk($sformatf("vec%0d_a1", i), a1, vecs[i].ea);
         chk($sformatf("vec%0d_b1", i), b1, vecs[i].eb);
      end

      // 256 back-to-back random ops, mode toggling every cycle
      for (int i = 0; i < 256; i++) begin
         r_sel[i] = i[0];
      end
      for (int c = 0; c < 256 + LAT + 3; c++) begin
         @(negedge clk);
         if (c >= LAT && c - LAT < 256) begin
            chk($sformatf("rnd%0d_valid", c - LAT), valid_out, 1);
            chk($sformatf("rnd%0d_a1", c - LAT), a1, r_ea[c - LAT]);
            chk($sformatf("rnd%0d_b1", c - LAT), b1, r_eb[c - LAT]);
         end else begin
            chk($sformatf("rnd_idle%0d_valid", c), valid_out, 0);
         end
         if (c < 256) begin
            x = (c % 17 == 0) ? 8380416 : int'($urandom_range(0, 8380416));
            y = (c % 13 == 0) ? 8380416 : int'($urandom_range(0, 8380416));
            w = (c % 11 == 0) ? 8380416 : int'($urandom_range(0, 8380416));
            model(r_sel[c], x, y, w, ea, eb);
            r_ea[c] = ea;
            r_eb[c] = eb;
            drive(1'b1, r_sel[c], x, y, w);
         end else begin
            drive(1'b0, 1'b0, 0, 0, 0);
         end
      end

      // reset with 5 ops in flight: they are discarded
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(1'b1, i[0], 1000 * (i + 1), 333 + i, 4567 + i);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("flight_rst_valid", valid_out, 0);
      chk("flight_rst_a1", a1, 0);
      chk("flight_rst_b1", b1, 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("flight_quiet%0d_valid", c), valid_out, 0);
      end

      // op accepted in the first cycle after reset deasserts
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b0, 5, 2, 4194304);
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 0, 0);
      repeat (LAT - 2) @(negedge clk);
      chk("post_rst_early_valid", valid_out, 0);
      @(negedge clk);
      chk("post_rst_valid", valid_out, 1);
      chk("post_rst_a1", a1, 8196);
      chk("post_rst_b1", b1, 8372231);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
